// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU encodings, state encoding and control word for the multicycle controller
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  // FETCH is encoding 0 so the debug state output reads 0 while in reset
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_uc_outdec.sv
// rtl/multicycle_uc_outdec.sv - Moore control-word decode from state, with mem_ready gating of the fetch strobes
module multicycle_uc_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctl_t   ctl
);

  // Every field defaults to 0; each state raises only its own controls
  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_op    = ALU_ADD;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b00;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = 2'b00;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
      end
      S_ADDI_WB: begin
        ctl.reg_write = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_uc.sv
// rtl/multicycle_uc.sv - multicycle MIPS control unit; MULTICYCLE_UC_PERF_EN adds instruction/stall counters
module multicycle_uc
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUop,
  output logic [1:0]  PCSource,
  output logic        illegal_op,
`ifdef MULTICYCLE_UC_PERF_EN
  output logic [31:0] instr_count,
  output logic [31:0] stall_count,
`endif
  output logic [3:0]  state_o
);

  state_t state_q, state_d;
  ctl_t   ctl_raw;
  ctl_t   ctl;

  // Zero feeds the datapath PC-write qualifier only; the FSM never looks at it
  logic unused_zero;
  assign unused_zero = Zero;

  multicycle_uc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctl       (ctl_raw)
  );

  // Next-state: Op is only consulted in DECODE and MEM_ADDR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register; reset drops straight to FETCH without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // FETCH decodes MemRead=1, so controls are forced low directly by rst_n
  assign ctl = rst_n ? ctl_raw : '0;

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUop       = ctl.alu_op;
  assign PCSource    = ctl.pc_source;
  assign illegal_op  = rst_n && (state_q == S_DECODE) && !op_is_legal(Op);
  assign state_o     = state_q;

`ifdef MULTICYCLE_UC_PERF_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Count completed fetches and memory wait cycles; both wrap naturally
  always_comb begin
    instr_count_d = instr_count_q;
    stall_count_d = stall_count_q;
    if (state_q == S_FETCH && mem_ready)
      instr_count_d = instr_count_q + 32'd1;
    if ((ctl.mem_read || ctl.mem_write) && !mem_ready)
      stall_count_d = stall_count_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_multicycle_uc.sv
// tb/tb_multicycle_uc.sv - scoreboard bench for multicycle_uc (optionally with MULTICYCLE_UC_PERF_EN)
module tb_multicycle_uc;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Op;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUop;
  logic [3:0]  state_o;
`ifdef MULTICYCLE_UC_PERF_EN
  logic [31:0] instr_count, stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_uc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op          (Op),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
`ifdef MULTICYCLE_UC_PERF_EN
    .instr_count (instr_count),
    .stall_count (stall_count),
`endif
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    state_t      st;
    logic [17:0] ctl;
    bit          pchk;
    logic [31:0] ic;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUop PCSource illegal_op
  function automatic logic [17:0] exp_ctl(input state_t st, input logic mr, input logic ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'b0;
    asb = 2'b00; aop = 3'b000; pcs = 2'b00;
    case (st)
      S_FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:    asb = 2'b11;
      S_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      S_MEM_RD:    begin mrd = 1; iord = 1; end
      S_MEM_WB:    begin rw = 1; m2r = 1; end
      S_MEM_WR:    begin mwr = 1; iord = 1; end
      S_R_EXEC:    begin asa = 1; aop = 3'b001; end
      S_R_WB:      begin rw = 1; rdst = 1; end
      S_BRANCH:    begin asa = 1; aop = 3'b010; pcwc = 1; pcs = 2'b01; end
      S_JUMP:      begin pcw = 1; pcs = 2'b10; end
      S_ADDI_EXEC: begin asa = 1; asb = 2'b10; end
      S_ADDI_WB:   rw = 1;
      default:     ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [17:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal_op};
      chk("state", {28'd0, state_o}, {28'd0, e.st});
      chk("ctl", {14'd0, act}, {14'd0, e.ctl});
      chk("rd_wr_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
`ifdef MULTICYCLE_UC_PERF_EN
      if (e.pchk) begin
        chk("instr_count", instr_count, e.ic);
        chk("stall_count", stall_count, e.sc);
      end
`endif
    end
  end

  task automatic put(input logic [5:0] op, input logic mr, input state_t st, input logic ill);
    exp_t e;
    Op = op; mem_ready = mr;
    e.st = st; e.ctl = exp_ctl(st, mr, ill); e.pchk = 0; e.ic = 0; e.sc = 0;
    q.push_back(e);
  endtask

  task automatic step(input logic [5:0] op, input logic mr, input state_t st, input logic ill = 1'b0);
    @(posedge clk); #1;
    put(op, mr, st, ill);
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e.st = S_FETCH; e.ctl = '0; e.pchk = 0; e.ic = 0; e.sc = 0;
    q.push_back(e);
  endtask

  task automatic reset_cycle();
    @(posedge clk); #1;
    rst_n = 1'b0; Op = 6'h00; mem_ready = 1'b1;
    push_reset_exp();
  endtask

  task automatic release_reset(input logic [5:0] op, input logic mr);
    @(posedge clk); #1;
    rst_n = 1'b1;
    put(op, mr, S_FETCH, 1'b0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; Op = 6'h00; Zero = 1'b0; mem_ready = 1'b1;

    // Reset, then R-type; Op change during R_EXEC must be ignored
    reset_cycle();
    reset_cycle();
    release_reset(OP_RTYPE, 1);
    step(OP_RTYPE, 1, S_DECODE);
    step(OP_LW,    1, S_R_EXEC);
    step(OP_RTYPE, 1, S_R_WB);

    // LW from fresh reset: 2 wait cycles in FETCH and in MEM_RD, 9 cycles total
    reset_cycle();
    release_reset(OP_LW, 0);
    step(OP_LW, 0, S_FETCH);
    step(OP_LW, 1, S_FETCH);
    step(OP_LW, 1, S_DECODE);
    step(OP_LW, 1, S_MEM_ADDR);
    step(OP_LW, 0, S_MEM_RD);
    step(OP_LW, 0, S_MEM_RD);
    step(OP_LW, 1, S_MEM_RD);
    step(OP_LW, 1, S_MEM_WB);
    @(posedge clk); #1;
    put(OP_SW, 1, S_FETCH, 1'b0);
    e = q.pop_back(); e.pchk = 1; e.ic = 32'd1; e.sc = 32'd4; q.push_back(e);

    // SW; Op changed during MEM_WR must be ignored
    step(OP_SW,    1, S_DECODE);
    step(OP_SW,    1, S_MEM_ADDR);
    step(OP_LW,    1, S_MEM_WR);
    step(OP_BEQ,   1, S_FETCH);

    // BEQ (Zero toggled to show it is not examined), J, ADDI
    Zero = 1'b1;
    step(OP_BEQ,   1, S_DECODE);
    step(OP_BEQ,   1, S_BRANCH);
    step(OP_J,     1, S_FETCH);
    Zero = 1'b0;
    step(OP_J,     1, S_DECODE);
    step(OP_J,     1, S_JUMP);
    step(OP_ADDI,  1, S_FETCH);
    step(OP_ADDI,  1, S_DECODE);
    step(OP_ADDI,  1, S_ADDI_EXEC);
    step(OP_ADDI,  1, S_ADDI_WB);

    // Illegal opcode pulses in DECODE and returns to FETCH
    step(6'h3F,    1, S_FETCH);
    step(6'h3F,    1, S_DECODE, 1'b1);
    step(OP_SW,    1, S_FETCH);

    // Reset asserted mid-cycle while stalled in MEM_WR
    step(OP_SW,    1, S_DECODE);
    step(OP_SW,    1, S_MEM_ADDR);
    step(OP_SW,    0, S_MEM_WR);
    @(posedge clk); #2;
    rst_n = 1'b0;
    push_reset_exp();
    reset_cycle();
    release_reset(OP_RTYPE, 1);
    step(OP_RTYPE, 1, S_DECODE);
    step(OP_RTYPE, 1, S_R_EXEC);
    step(OP_RTYPE, 1, S_R_WB);
    step(OP_RTYPE, 1, S_FETCH);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_uc.md
MULTICYCLE_UC -- requirements
Module: multicycle_uc

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Op  in  6  opcode field of the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 1 = MDR.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- ALUop  out  3  ALU control: 000 = add, 001 = R-type (funct), 010 = subtract.
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  4  current state (debug).

Function
REQ-010 SHALL be a Moore FSM; outputs SHALL decode from state only, except IRWrite and PCWrite in FETCH, which SHALL be gated by mem_ready.
REQ-011 The FSM SHALL have these states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
REQ-012 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000 and PCSource=00.
- Holds in FETCH while mem_ready=0.
- When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
REQ-013 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUop=000, then dispatch on Op:
- 0x00 -> R_EXEC
- 0x23 or 0x2B -> MEM_ADDR
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x08 -> ADDI_EXEC
- any other Op -> FETCH, with illegal_op=1 in this DECODE cycle.
REQ-014 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUop=000, then go to MEM_RD if Op=0x23, else MEM_WR.
REQ-015 MEM_RD SHALL drive MemRead=1 and IorD=1, hold until mem_ready=1, then go to MEM_WB.
REQ-016 MEM_WB SHALL drive RegWrite=1, MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-017 MEM_WR SHALL drive MemWrite=1 and IorD=1, hold until mem_ready=1, then go to FETCH.
REQ-018 R_EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUop=001, then go to R_WB.
REQ-019 R_WB SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUop=010, PCWriteCond=1 and PCSource=01, then go to FETCH.
- Zero is not examined by the FSM.
REQ-021 JUMP SHALL drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-022 ADDI_EXEC SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUop=000, then go to ADDI_WB.
REQ-023 ADDI_WB SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0, then go to FETCH.
REQ-024 Every output not listed for a state SHALL be 0 in that state.
REQ-025 MemRead and MemWrite SHALL never be asserted in the same cycle.
REQ-026 Cycle counts with mem_ready tied to 1 SHALL be:
- R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
- Each mem_ready=0 cycle adds exactly one cycle.
REQ-027 Op SHALL be sampled only in DECODE and MEM_ADDR; Op changes in other states SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately force the state to FETCH, independent of clk.
REQ-031 While rst_n=0, all outputs SHALL be 0.
REQ-032 Reset asserted mid-instruction SHALL abandon that instruction; no write strobe SHALL be issued after reset asserts.
REQ-033 The first cycle after rst_n rises SHALL be a FETCH with MemRead=1.

Configuration
REQ-040 Macro MULTICYCLE_UC_PERF_EN, when defined, SHALL add these outputs:
- instr_count (out, 32): increments on every FETCH->DECODE transition.
- stall_count (out, 32): increments on every cycle where MemRead or MemWrite is 1 and mem_ready=0.
REQ-041 Both counters SHALL reset to 0 and wrap modulo 2^32.
REQ-042 Without the macro, neither port nor any counter logic SHALL exist.

Structure
REQ-050 Shared package mips_pkg SHALL hold:
- the opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
- the ALUop encodings
- the 4-bit state encoding
REQ-051 A single sub-module, multicycle_uc_outdec (state + mem_ready -> control outputs), SHALL be instantiated; the next-state logic SHALL stay in the top level.

Verification
REQ-060 The bench SHALL cover these directed scenarios:
- Reset release, mem_ready=1, Op=0x00: states FETCH, DECODE, R_EXEC, R_WB, FETCH; RegWrite=1 and RegDst=1 only in cycle 4.
- Op=0x23, mem_ready low for 2 cycles in both FETCH and MEM_RD: LW takes 9 cycles; IRWrite pulses once; RegWrite with MemtoReg=1 once.
- Op=0x2B: MemWrite=1, IorD=1 for exactly 1 cycle; RegWrite never asserted.
- Op=0x04, then Op=0x02: PCWriteCond=1 with ALUop=010 for BEQ; PCWrite=1 with PCSource=10 for J; each takes 3 cycles.
- Op=0x3F: illegal_op pulses 1 cycle in DECODE; next state FETCH; no write strobe asserted.
- rst_n low during MEM_WR: outputs go to 0 immediately; the next state after release is FETCH.
- With MULTICYCLE_UC_PERF_EN defined: after the 9-cycle LW scenario above, instr_count=1 and stall_count=4.
